// File: rtl/inv_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_pkg
//  Description : Shared definitions for the sequential inverse SubBytes
//                stage. It holds the state-word geometry, the AES inverse
//                S-box table, a lookup helper and the FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package inv_sub_pkg;

    // Bytes per state word. Only 8 (a 64-bit state) is supported.
    localparam int NBYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Standard AES inverse S-box. The table is indexed by the input byte.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox_lookup(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

endpackage : inv_sub_pkg
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sbox
//  Description : Combinational AES inverse S-box lookup of one byte.
//  Revision    : 1.0 - initial release
//  Ports       : i_byte  [7:0]  input byte
//                o_byte  [7:0]  inverse-substituted byte
// ============================================================================
module inv_sbox
    import inv_sub_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = inv_sbox_lookup(i_byte);

endmodule : inv_sbox
`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_bytes_seq
//  Description : Sequential inverse SubBytes stage for a 64-bit state word.
//                A word is accepted over a valid/ready handshake, its bytes
//                are run through a shared inverse S-box one (or two) per
//                cycle, and the finished word is offered downstream over a
//                second valid/ready handshake.
//  Revision    : 1.0 - initial release
//  Build option: INV_SUB_FAST_EN - two lookups per cycle (4 SUB cycles/word)
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                in_valid   upstream word available
//                in_ready   stage can accept a word this cycle
//                in_data    [63:0] state word, byte 0 = in_data[63:56]
//                out_valid  out_data holds a fully substituted word
//                out_ready  downstream accepts out_data this cycle
//                out_data   [63:0] working register, same byte order
//                busy       high while substituting
// ============================================================================
module inv_sub_bytes_seq
    import inv_sub_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NBYTES*8-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NBYTES*8-1:0]   out_data,
    output logic                  busy
);

`ifdef INV_SUB_FAST_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif

    state_t                r_state;
    logic [NBYTES*8-1:0]   r_work;
    logic [2:0]            r_idx;
    logic                  r_out_valid;
    logic                  r_busy;

    logic [2:0]            w_lane_idx [LANES];
    logic [7:0]            w_lane_in  [LANES];
    logic [7:0]            w_lane_out [LANES];
    logic [NBYTES*8-1:0]   w_work_sub;
    logic                  w_last;
    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;

    // Byte n lives at bit offset 8*(7-n); for a 3-bit n, 7-n is simply ~n.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_idx[l] = r_idx + 3'(l);
        assign w_lane_in[l]  = r_work[{~w_lane_idx[l], 3'b000} +: 8];

        inv_sbox u_inv_sbox (
            .i_byte (w_lane_in[l]),
            .o_byte (w_lane_out[l])
        );
    end

    always_comb begin
        w_work_sub = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_work_sub[{~w_lane_idx[l], 3'b000} +: 8] = w_lane_out[l];
        end
    end

    // The highest lane reaching byte 7 marks the final SUB edge of a word.
    assign w_last     = (w_lane_idx[LANES-1] == 3'd7);

    // A word may be loaded in DONE on the same edge the finished word leaves,
    // so back-to-back words see no idle bubble.
    assign w_in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = (r_state == DONE) & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_idx       <= 3'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_work      <= in_data;
                        r_idx       <= 3'd0;
                        r_state     <= SUB;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                SUB: begin
                    r_work <= w_work_sub;
                    // Wraps to 0 on the final edge (7+1 or 6+2).
                    r_idx  <= r_idx + 3'(LANES);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (w_in_fire) begin
                        r_work      <= in_data;
                        r_idx       <= 3'd0;
                        r_state     <= SUB;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_data  = r_work;

endmodule : inv_sub_bytes_seq
`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_sub_bytes_seq
//  Description : Self-checking bench for inv_sub_bytes_seq. Reference inverse
//                S-box is derived from GF(2^8) inversion plus the AES affine
//                map; expected words are queued on input handshakes and
//                compared on output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_sub_bytes_seq;

`ifdef INV_SUB_FAST_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_tbl [256];
    logic [63:0] sb [$];

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_ref();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            ref_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] w);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = ref_tbl[w[8*j +: 8]];
        return r;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", out_data, 64'hx);
                end else begin
                    logic [63:0] exp_w;
                    exp_w = sb.pop_front();
                    check("sb_data", out_data, exp_w);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [63:0] w;
        logic [63:0] held;

        build_ref();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'h0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_data",  out_data,       64'h0);
        rst_n = 1'b1;
        step();

        // Known vector and latency
        out_ready = 1'b1;
        send(64'h637C777BF26B6FC5);
        check("kv_busy", 64'(busy), 64'd1);
        wait_valid(n);
        check("kv_latency", 64'(n), 64'(LAT));
        check("kv_data", out_data, 64'h0001020304050607);
        step();
        check("kv_idle_valid", 64'(out_valid), 64'd0);
        check("kv_idle_ready", 64'(in_ready),  64'd1);

        // Backpressure
        out_ready = 1'b0;
        send(64'h0123456789ABCDEF);
        wait_valid(n);
        check("bp_latency", 64'(n), 64'(LAT));
        held = out_data;
        check("bp_data", held, model(64'h0123456789ABCDEF));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!out_valid || out_data !== held || in_ready) seen = 1'b1;
        end
        check("bp_stable", 64'(seen), 64'd0);
        out_ready = 1'b1;
        #1;
        check("bp_ready_on_release", 64'(in_ready), 64'd1);
        step();
        check("bp_idle_valid", 64'(out_valid), 64'd0);
        check("bp_idle_busy",  64'(busy),      64'd0);

        // Back-to-back with no bubble
        in_valid = 1'b1;
        in_data  = 64'h6363636363636363;
        step();
        in_data  = 64'h0000000000000000;
        wait_valid(n);
        check("b2b_first_latency", 64'(n), 64'(LAT));
        check("b2b_first_data", out_data, 64'h0000000000000000);
        check("b2b_ready_in_done", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("b2b_period", 64'(n + 1), 64'(LAT + 1));
        check("b2b_reload_busy", 64'(busy), 64'd1);
        wait_valid(n);
        check("b2b_second_latency", 64'(n), 64'(LAT));
        check("b2b_second_data", out_data, 64'h5252525252525252);
        step();

        // Input offered while busy must be ignored
        send(64'h1234567890ABCDEF);
        step();
        in_valid = 1'b1;
        in_data  = 64'hFFFFFFFFFFFFFFFF;
        #1;
        check("busy_in_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check("busy_data", out_data, model(64'h1234567890ABCDEF));
        step();
        step();
        check("busy_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-operation
        send(64'hFEFEFEFEFEFEFEFE);
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",  64'(busy),      64'd0);
        check("mid_rst_ready", 64'(in_ready),  64'd1);
        check("mid_rst_data",  out_data,       64'h0);
        sb.delete();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_pulse", 64'(seen), 64'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 64'(in_ready), 64'd1);
        send(64'hFEFEFEFEFEFEFEFE);
        wait_valid(n);
        check("post_rst_latency", 64'(n), 64'(LAT));
        check("post_rst_data", out_data, 64'h0C0C0C0C0C0C0C0C);
        step();

        // All 256 byte values across 32 words, rotated through positions
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 8; j++) w[8*(7-j) +: 8] = 8'(8*k + ((j + k) % 8));
            send(w);
        end
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inv_sub_bytes_seq
`default_nettype wire
